// File: rtl/hex_display_pkg.sv
// Shared constants for the hex seven-segment display path: active-low glyph
// table, blank pattern and segment bit positions (gfedcba, a = bit 0).
package hex_display_pkg;

  localparam int unsigned SEG_W = 7;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Index 15 is leftmost: F, E, d, C, b, A, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble-to-segment lookup producing the active-low glyph;
// polarity and blanking are applied by the caller.
module hex_seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/hex_display_ctrl.sv
// Registered multi-digit hex display driver with per-digit mask, leading-zero
// blanking and a prescaled blink; two-cycle write-to-pin latency.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int BLINK_DIV      = 25000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [4*NUM_DIGITS-1:0]     wr_data,
  input  logic                        cfg_wr,
  input  logic [NUM_DIGITS-1:0]       cfg_mask,
  input  logic                        cfg_lzb,
  input  logic                        cfg_blink,
  output logic [SEG_W*NUM_DIGITS-1:0] hex_segs,
  output logic                        blink_ph
);

  localparam int CNT_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
  localparam logic [SEG_W-1:0] POL_MASK = SEG_ACTIVE_LOW ? 7'h00 : 7'h7F;

  logic [4*NUM_DIGITS-1:0]     value_q;
  logic [NUM_DIGITS-1:0]       mask_q;
  logic                        lzb_q;
  logic                        blink_q;
  logic [CNT_W-1:0]            cnt_q;
  logic                        ph_q;
  logic [SEG_W*NUM_DIGITS-1:0] raw_segs;
  logic [SEG_W*NUM_DIGITS-1:0] segs_d;
  logic [SEG_W*NUM_DIGITS-1:0] segs_q;
  logic                        zero_above;
  logic                        blank;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex_seg_decode u_dec (
      .nibble (value_q[4*g +: 4]),
      .seg    (raw_segs[SEG_W*g +: SEG_W])
    );
  end

  // Walk from the most significant digit down so zero_above accumulates
  // "this nibble and every nibble to its left is zero".
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path can
    // leave one unassigned and infer a latch.
    zero_above = 1'b1;
    blank      = 1'b0;
    segs_d     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (value_q[4*i +: 4] == 4'h0);
      blank      = ~mask_q[i]
                 | (lzb_q & zero_above & (i != 0))
                 | (blink_q & ph_q);
      segs_d[SEG_W*i +: SEG_W] = (blank ? SEG_BLANK : raw_segs[SEG_W*i +: SEG_W]) ^ POL_MASK;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      value_q <= '0;
      mask_q  <= '1;
      lzb_q   <= 1'b0;
      blink_q <= 1'b0;
      cnt_q   <= '0;
      ph_q    <= 1'b0;
      // NOTE: the output register is reset too, so the pins show "0" on the
      // edge reset is sampled rather than one cycle later.
      segs_q  <= {NUM_DIGITS{SEG_TABLE[0] ^ POL_MASK}};
    end else begin
      if (wr_en) begin
        value_q <= wr_data;
      end
      // Any config write restarts the blink phase, enabled or not.
      if (cfg_wr) begin
        mask_q  <= cfg_mask;
        lzb_q   <= cfg_lzb;
        blink_q <= cfg_blink;
        cnt_q   <= '0;
        ph_q    <= 1'b0;
      end else if (blink_q) begin
        if (cnt_q == CNT_LAST) begin
          cnt_q <= '0;
          ph_q  <= ~ph_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      segs_q <= segs_d;
    end
  end

  assign hex_segs = segs_q;
  assign blink_ph = ph_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl (4 digits, BLINK_DIV=4, active-low):
// stimulus queues expected pin state per cycle, a negedge monitor compares.
module tb_hex_display_ctrl;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [15:0]   wr_data;
  logic          cfg_wr;
  logic [3:0]    cfg_mask;
  logic          cfg_lzb;
  logic          cfg_blink;
  logic [27:0]   hex_segs;
  logic          blink_ph;

  typedef struct {
    int          cyc;
    logic [27:0] segs;
    logic        ph;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [27:0] ALL0  = {4{7'h40}};
  localparam logic [27:0] BLANK = {4{7'h7F}};

  hex_display_ctrl #(
    .NUM_DIGITS     (N),
    .BLINK_DIV      (4),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .cfg_wr    (cfg_wr),
    .cfg_mask  (cfg_mask),
    .cfg_lzb   (cfg_lzb),
    .cfg_blink (cfg_blink),
    .hex_segs  (hex_segs),
    .blink_ph  (blink_ph)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [27:0] digs(input logic [6:0] d3, input logic [6:0] d2,
                                       input logic [6:0] d1, input logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  // Expected state at the negedge sample after posedge number c.
  task automatic expect_at(input int c, input logic [27:0] segs, input logic ph, input string name);
    exp_t e;
    int   idx;
    e.cyc = c; e.segs = segs; e.ph = ph; e.name = name;
    idx = sb.size();
    while (idx > 0 && sb[idx-1].cyc > c) idx--;
    sb.insert(idx, e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || hex_segs !== e.segs || blink_ph !== e.ph) begin
        errors++;
        $display("FAIL %s @cyc %0d (due %0d): hex_segs=%h blink_ph=%b, expected hex_segs=%h blink_ph=%b",
                 e.name, cyc, e.cyc, hex_segs, blink_ph, e.segs, e.ph);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic do_wr, input logic [15:0] data, input logic do_cfg,
                       input logic [3:0] mask, input logic lzb, input logic blink);
    wr_en = do_wr; wr_data = data;
    cfg_wr = do_cfg; cfg_mask = mask; cfg_lzb = lzb; cfg_blink = blink;
    tick(1);
    wr_en = 1'b0; cfg_wr = 1'b0;
  endtask

  initial begin
    int e0;
    int s;
    logic [27:0] v;

    reset = 1'b1; wr_en = 1'b0; wr_data = '0;
    cfg_wr = 1'b0; cfg_mask = 4'hF; cfg_lzb = 1'b0; cfg_blink = 1'b0;

    // 1. reset state
    tick(2);
    reset = 1'b0;
    expect_at(cyc,     ALL0, 1'b0, "reset_0");
    expect_at(cyc + 1, ALL0, 1'b0, "reset_1");
    expect_at(cyc + 3, ALL0, 1'b0, "reset_3");
    tick(3);

    // 2. plain write, two-cycle latency
    expect_at(cyc + 1, ALL0, 1'b0, "wr_latency");
    expect_at(cyc + 2, digs(7'h08, 7'h79, 7'h00, 7'h0E), 1'b0, "wr_A18F");
    drive(1'b1, 16'hA18F, 1'b0, 4'hF, 1'b0, 1'b0);
    tick(2);

    // 3. leading-zero blanking, written together with the value
    expect_at(cyc + 1, digs(7'h08, 7'h79, 7'h00, 7'h0E), 1'b0, "cfg_latency");
    expect_at(cyc + 2, digs(7'h7F, 7'h7F, 7'h78, 7'h40), 1'b0, "lzb_0070");
    drive(1'b1, 16'h0070, 1'b1, 4'hF, 1'b1, 1'b0);
    expect_at(cyc + 2, digs(7'h7F, 7'h7F, 7'h7F, 7'h40), 1'b0, "lzb_zero");
    drive(1'b1, 16'h0000, 1'b0, 4'hF, 1'b0, 1'b0);
    expect_at(cyc + 2, digs(7'h7F, 7'h79, 7'h40, 7'h40), 1'b0, "lzb_0100");
    drive(1'b1, 16'h0100, 1'b0, 4'hF, 1'b0, 1'b0);
    tick(2);

    // 4. per-digit mask
    expect_at(cyc + 2, digs(7'h7F, 7'h24, 7'h7F, 7'h19), 1'b0, "mask_0101");
    drive(1'b1, 16'h1234, 1'b1, 4'b0101, 1'b0, 1'b0);
    tick(2);

    // 5. blink: phase toggles every 4 cycles, pins follow one cycle later
    v  = digs(7'h79, 7'h24, 7'h30, 7'h19);
    e0 = cyc + 1;
    for (int n = 1; n <= 13; n++) begin
      expect_at(e0 + n, ((((n - 1) / 4) % 2) == 1) ? BLANK : v, 1'(((n / 4) % 2) == 1), "blink");
    end
    drive(1'b0, 16'h0000, 1'b1, 4'hF, 1'b0, 1'b1);
    tick(13);
    expect_at(cyc + 1, BLANK, 1'b0, "unblink_1");
    expect_at(cyc + 2, v,     1'b0, "unblink_2");
    drive(1'b0, 16'h0000, 1'b1, 4'hF, 1'b0, 1'b0);
    tick(3);

    // 6. same-cycle write + blink enable, then reset mid-blink with a pending write
    expect_at(cyc + 2, digs(7'h03, 7'h06, 7'h06, 7'h0E), 1'b0, "same_cycle");
    e0 = cyc + 1;
    drive(1'b1, 16'hBEEF, 1'b1, 4'hF, 1'b0, 1'b1);
    tick(5);
    expect_at(e0 + 5, BLANK, 1'b1, "pre_reset_blank");
    s = cyc;
    reset = 1'b1; wr_en = 1'b1; wr_data = 16'h5555;
    expect_at(s + 1, ALL0, 1'b0, "reset_mid_blink");
    expect_at(s + 2, ALL0, 1'b0, "reset_discard_1");
    expect_at(s + 3, ALL0, 1'b0, "reset_discard_2");
    tick(1);
    reset = 1'b0; wr_en = 1'b0;
    tick(3);

    for (int k = 0; k < 50 && sb.size() > 0; k++) tick(1);
    if (sb.size() > 0) begin
      errors += sb.size();
      $display("FAIL drain: %0d expected entries never compared, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
